// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: request/acknowledge bus access with alignment check,
// bus timeout and little-endian lane extraction. States: IDLE wait for op | BUSY bus outstanding | DONE present result.
module mem_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          wd_i,
  input  logic                wreg_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [7:0]          aluop_i,
  input  logic [XLEN-1:0]     mem_addr_i,
  input  logic [XLEN-1:0]     reg2_i,
  input  logic                flush_i,
  output logic                stall_req_o,
  output logic                req_o,
  output logic                we_o,
  output logic [XLEN-1:0]     addr_o,
  output logic [XLEN/8-1:0]   sel_o,
  output logic [XLEN-1:0]     bus_wdata_o,
  input  logic                ack_i,
  input  logic                err_i,
  input  logic [XLEN-1:0]     rdata_i,
  output logic [4:0]          wd_o,
  output logic                wreg_o,
  output logic [XLEN-1:0]     wdata_o,
  output logic                misalign_o,
  output logic                bus_err_o
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = 16;

  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_LWU_OP = 8'hE6;
  localparam logic [7:0] EXE_LD_OP  = 8'hE7;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;
  localparam logic [7:0] EXE_SD_OP  = 8'hEF;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q;
  logic              we_q, wreg_q, load_q, signed_q, kill_q, err_q;
  logic [1:0]        size_q;
  logic [4:0]        wd_q;
  logic [XLEN-1:0]   addr_q, bwd_q, ld_data_q;
  logic [NB-1:0]     sel_q;
  logic [CW-1:0]     cnt_q;

  logic              dec_mem, dec_load, dec_signed, misal;
  logic [1:0]        dec_size;
  logic [NB-1:0]     sel_d;
  logic [XLEN-1:0]   bwd_d, ld_field, ld_data_d;
  logic signed [XLEN-1:0] ld_shl;
  logic [6:0]        ld_sh;

  always_comb begin
    dec_mem    = 1'b1;
    dec_load   = 1'b1;
    dec_signed = 1'b1;
    dec_size   = 2'd0;
    case (aluop_i)
      EXE_LB_OP:  ;
      EXE_LBU_OP: dec_signed = 1'b0;
      EXE_LH_OP:  dec_size = 2'd1;
      EXE_LHU_OP: begin dec_size = 2'd1; dec_signed = 1'b0; end
      EXE_LW_OP:  dec_size = 2'd2;
      EXE_LWU_OP: begin dec_size = 2'd2; dec_signed = 1'b0; dec_mem = (XLEN == 64); end
      EXE_LD_OP:  begin dec_size = 2'd3; dec_mem = (XLEN == 64); end
      EXE_SB_OP:  dec_load = 1'b0;
      EXE_SH_OP:  begin dec_load = 1'b0; dec_size = 2'd1; end
      EXE_SW_OP:  begin dec_load = 1'b0; dec_size = 2'd2; end
      EXE_SD_OP:  begin dec_load = 1'b0; dec_size = 2'd3; dec_mem = (XLEN == 64); end
      default:    begin dec_mem = 1'b0; dec_load = 1'b0; end
    endcase

    case (dec_size)
      2'd1:    misal = mem_addr_i[0];
      2'd2:    misal = |mem_addr_i[1:0];
      2'd3:    misal = |mem_addr_i[2:0];
      default: misal = 1'b0;
    endcase

    case (dec_size)
      2'd0:    begin sel_d = NB'(1)    << mem_addr_i[OB-1:0]; bwd_d = {NB{reg2_i[7:0]}}; end
      2'd1:    begin sel_d = NB'(2'h3) << mem_addr_i[OB-1:0]; bwd_d = {(NB/2){reg2_i[15:0]}}; end
      2'd2:    begin sel_d = NB'(4'hF) << mem_addr_i[OB-1:0]; bwd_d = {(NB/4){reg2_i[31:0]}}; end
      default: begin sel_d = '1; bwd_d = reg2_i; end
    endcase
  end

  // Shift the field to the top, then back down arithmetically or logically to extend.
  always_comb begin
    ld_field  = rdata_i >> {addr_q[OB-1:0], 3'b000};
    ld_sh     = 7'(XLEN) - (7'd8 << size_q);
    ld_shl    = ld_field << ld_sh;
    ld_data_d = signed_q ? XLEN'(ld_shl >>> ld_sh) : XLEN'(ld_shl >> ld_sh);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      kill_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      wreg_q    <= 1'b0;
      load_q    <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= 2'd0;
      wd_q      <= '0;
      addr_q    <= '0;
      bwd_q     <= '0;
      sel_q     <= '0;
      ld_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dec_mem && !misal && !flush_i) begin
            state_q  <= BUSY;
            we_q     <= ~dec_load;
            wreg_q   <= wreg_i;
            load_q   <= dec_load;
            signed_q <= dec_signed;
            size_q   <= dec_size;
            wd_q     <= wd_i;
            addr_q   <= mem_addr_i;
            bwd_q    <= bwd_d;
            sel_q    <= sel_d;
            kill_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          if (flush_i) kill_q <= 1'b1;
          if (err_i) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (ack_i) begin
            ld_data_q <= ld_data_d;
            state_q   <= DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_o       = 1'b0;
    we_o        = 1'b0;
    addr_o      = '0;
    sel_o       = '0;
    bus_wdata_o = '0;
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    case (state_q)
      IDLE: begin
        if (dec_mem) begin
          wreg_o = 1'b0;
          if (misal) misalign_o = 1'b1;
          else       stall_req_o = ~flush_i;
        end
      end
      BUSY: begin
        req_o       = 1'b1;
        we_o        = we_q;
        addr_o      = addr_q;
        sel_o       = sel_q;
        bus_wdata_o = bwd_q;
        stall_req_o = 1'b1;
        wd_o        = wd_q;
        wreg_o      = 1'b0;
        wdata_o     = '0;
      end
      default: begin
        wd_o      = wd_q;
        wreg_o    = wreg_q & load_q & ~kill_q & ~err_q;
        wdata_o   = load_q ? ld_data_q : '0;
        bus_err_o = err_q & ~kill_q;
      end
    endcase
    if (!rst) begin
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = '0;
      stall_req_o = 1'b0;
      misalign_o  = 1'b0;
      bus_err_o   = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit instance with a short timeout and a 64-bit instance.
module tb_mem_lsu;
  localparam logic [7:0] OP_NOP = 8'h21;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LWU = 8'hE6;
  localparam logic [7:0] OP_LD  = 8'hE7;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SD  = 8'hEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // 32-bit instance, TIMEOUT=4
  logic        a_rst, a_wreg, a_flush, a_ack, a_err;
  logic [4:0]  a_wd, a_wd_o;
  logic [7:0]  a_op;
  logic [31:0] a_wdata, a_addr, a_reg2, a_rdata;
  logic        a_stall, a_req, a_we, a_wreg_o, a_mis, a_berr;
  logic [31:0] a_addr_o, a_bwd, a_wdata_o;
  logic [3:0]  a_sel;

  mem_lsu #(.XLEN(32), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(a_rst), .wd_i(a_wd), .wreg_i(a_wreg), .wdata_i(a_wdata),
    .aluop_i(a_op), .mem_addr_i(a_addr), .reg2_i(a_reg2), .flush_i(a_flush),
    .stall_req_o(a_stall), .req_o(a_req), .we_o(a_we), .addr_o(a_addr_o),
    .sel_o(a_sel), .bus_wdata_o(a_bwd), .ack_i(a_ack), .err_i(a_err),
    .rdata_i(a_rdata), .wd_o(a_wd_o), .wreg_o(a_wreg_o), .wdata_o(a_wdata_o),
    .misalign_o(a_mis), .bus_err_o(a_berr)
  );

  // 64-bit instance, default timeout
  logic        b_rst, b_wreg, b_flush, b_ack, b_err;
  logic [4:0]  b_wd, b_wd_o;
  logic [7:0]  b_op;
  logic [63:0] b_wdata, b_addr, b_reg2, b_rdata;
  logic        b_stall, b_req, b_we, b_wreg_o, b_mis, b_berr;
  logic [63:0] b_addr_o, b_bwd, b_wdata_o;
  logic [7:0]  b_sel;

  mem_lsu #(.XLEN(64)) u_b (
    .clk(clk), .rst(b_rst), .wd_i(b_wd), .wreg_i(b_wreg), .wdata_i(b_wdata),
    .aluop_i(b_op), .mem_addr_i(b_addr), .reg2_i(b_reg2), .flush_i(b_flush),
    .stall_req_o(b_stall), .req_o(b_req), .we_o(b_we), .addr_o(b_addr_o),
    .sel_o(b_sel), .bus_wdata_o(b_bwd), .ack_i(b_ack), .err_i(b_err),
    .rdata_i(b_rdata), .wd_o(b_wd_o), .wreg_o(b_wreg_o), .wdata_o(b_wdata_o),
    .misalign_o(b_mis), .bus_err_o(b_berr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int nreq, nst, nb;
  logic [7:0] b_sel_seen;

  initial begin
    a_rst = 1'b0; a_wd = 5'd9; a_wreg = 1'b1; a_wdata = 32'hDEAD; a_op = OP_NOP;
    a_addr = '0; a_reg2 = '0; a_flush = 1'b0; a_ack = 1'b0; a_err = 1'b0; a_rdata = '0;
    b_rst = 1'b0; b_wd = 5'd0; b_wreg = 1'b0; b_wdata = '0; b_op = OP_NOP;
    b_addr = '0; b_reg2 = '0; b_flush = 1'b0; b_ack = 1'b0; b_err = 1'b0; b_rdata = '0;
    tick(); tick(); #1;
    check("rst_wreg", a_wreg_o, 0);
    check("rst_wdata", a_wdata_o, 0);
    check("rst_req", a_req, 0);
    check("rst_stall", a_stall, 0);

    // non-memory pass-through
    tick(); a_rst = 1'b1; b_rst = 1'b1; a_wd = 5'd5; a_wdata = 32'h1111; #1;
    check("pass_wd", a_wd_o, 5);
    check("pass_wreg", a_wreg_o, 1);
    check("pass_wdata", a_wdata_o, 32'h1111);
    check("pass_stall", a_stall, 0);

    // LB 0x1003, zero-wait ack
    tick(); a_op = OP_LB; a_addr = 32'h1003; a_wd = 5'd7; a_rdata = 32'h8000_0000; #1;
    check("lb_idle_stall", a_stall, 1);
    check("lb_idle_wreg", a_wreg_o, 0);
    check("lb_idle_req", a_req, 0);
    tick(); a_ack = 1'b1; #1;
    check("lb_busy_req", a_req, 1);
    check("lb_busy_sel", a_sel, 4'b1000);
    check("lb_busy_addr", a_addr_o, 32'h1003);
    check("lb_busy_we", a_we, 0);
    check("lb_busy_stall", a_stall, 1);
    tick(); a_ack = 1'b0; #1;
    check("lb_done_stall", a_stall, 0);
    check("lb_done_req", a_req, 0);
    check("lb_done_wd", a_wd_o, 7);
    check("lb_done_wreg", a_wreg_o, 1);
    check("lb_done_wdata", a_wdata_o, 32'hFFFF_FF80);

    // SH 0x2002, ack in second BUSY cycle
    tick(); a_op = OP_SH; a_addr = 32'h2002; a_reg2 = 32'h1234_ABCD; #1;
    tick(); a_op = OP_NOP; #1;
    check("sh_we", a_we, 1);
    check("sh_sel", a_sel, 4'b1100);
    check("sh_bwd", a_bwd, 32'hABCD_ABCD);
    tick(); a_ack = 1'b1; #1;
    check("sh_req2", a_req, 1);
    check("sh_bwd2", a_bwd, 32'hABCD_ABCD);
    tick(); a_ack = 1'b0; #1;
    check("sh_done_wreg", a_wreg_o, 0);
    check("sh_done_stall", a_stall, 0);

    // LW misaligned
    tick(); a_op = OP_LW; a_addr = 32'h3001; #1;
    check("mis_flag", a_mis, 1);
    check("mis_wreg", a_wreg_o, 0);
    check("mis_stall", a_stall, 0);
    tick(); a_op = OP_NOP; #1;
    check("mis_req", a_req, 0);
    check("mis_clear", a_mis, 0);

    // timeout: no ack
    tick(); a_op = OP_LW; a_addr = 32'h4000; #1;
    tick(); a_op = OP_NOP; #1;
    nreq = 0;
    for (int i = 0; i < 10 && a_req; i++) begin
      nreq++;
      tick(); #1;
    end
    check("to_req_cycles", nreq, 4);
    check("to_berr", a_berr, 1);
    check("to_wreg", a_wreg_o, 0);

    // flush during BUSY, later ack
    tick(); a_op = OP_LW; a_addr = 32'h5000; a_rdata = 32'h1234_5678; #1;
    tick(); a_op = OP_NOP; a_flush = 1'b1; #1;
    tick(); a_flush = 1'b0; a_ack = 1'b1; #1;
    check("fl_req", a_req, 1);
    tick(); a_ack = 1'b0; #1;
    check("fl_wreg", a_wreg_o, 0);
    check("fl_berr", a_berr, 0);

    // err_i beats ack_i
    tick(); a_op = OP_LW; a_addr = 32'h5004; #1;
    tick(); a_op = OP_NOP; a_err = 1'b1; a_ack = 1'b1; #1;
    tick(); a_err = 1'b0; a_ack = 1'b0; #1;
    check("err_berr", a_berr, 1);
    check("err_wreg", a_wreg_o, 0);

    // reset in second BUSY cycle, then a clean LW
    tick(); a_op = OP_LW; a_addr = 32'h6000; #1;
    tick(); a_op = OP_NOP; #1;
    tick(); a_rst = 1'b0; #1;
    tick(); #1;
    check("rst_mid_req", a_req, 0);
    check("rst_mid_stall", a_stall, 0);
    a_rst = 1'b1; #1;
    check("rst_mid_idle", a_stall, 0);
    tick(); a_op = OP_LW; a_addr = 32'h6004; a_rdata = 32'hCAFE_BABE; a_wd = 5'd3; #1;
    tick(); a_op = OP_NOP; a_ack = 1'b1; #1;
    check("post_rst_req", a_req, 1);
    tick(); a_ack = 1'b0; #1;
    check("post_rst_wdata", a_wdata_o, 32'hCAFE_BABE);
    check("post_rst_wreg", a_wreg_o, 1);

    // 64-bit LWU at 0x...04, ack in third BUSY cycle
    tick(); b_op = OP_LWU; b_addr = 64'h1004; b_wd = 5'd3; b_wreg = 1'b1;
    b_rdata = 64'hF000_0000_0000_0000; #1;
    nst = 0; nb = 0; b_sel_seen = '0;
    for (int i = 0; i < 20 && b_stall; i++) begin
      nst++;
      if (b_req) begin nb++; b_sel_seen = b_sel; end
      tick();
      b_ack = (nb == 2);
      #1;
    end
    check("lwu_stall_cycles", nst, 4);
    check("lwu_sel", b_sel_seen, 8'hF0);
    check("lwu_wdata", b_wdata_o, 64'h0000_0000_F000_0000);
    check("lwu_wreg", b_wreg_o, 1);

    // 64-bit LW sign-extends the same word
    tick(); b_op = OP_LW; #1;
    tick(); b_op = OP_NOP; b_ack = 1'b1; #1;
    tick(); b_ack = 1'b0; #1;
    check("lw64_wdata", b_wdata_o, 64'hFFFF_FFFF_F000_0000);

    // 64-bit LD full lanes, misaligned SD
    tick(); b_op = OP_LD; b_addr = 64'h2000; b_rdata = 64'h8123_4567_89AB_CDEF; #1;
    tick(); b_op = OP_NOP; b_ack = 1'b1; #1;
    check("ld_sel", b_sel, 8'hFF);
    tick(); b_ack = 1'b0; #1;
    check("ld_wdata", b_wdata_o, 64'h8123_4567_89AB_CDEF);
    tick(); b_op = OP_SD; b_addr = 64'h2004; #1;
    check("sd_mis", b_mis, 1);
    tick(); b_op = OP_NOP; #1;
    check("sd_req", b_req, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
